// File: rtl/step_ex_alu.sv
// step_ex_alu: digit-serial 8-op ALU for the sequencer EX stage.
//
// Operands are latched on the start edge. They are then combined SLICE bits
// per clock, least significant slice first, with the carry held in a register
// between slices. The result and the {C,Z} flags are written back over the
// shared open-drain strobe / tri-state bus convention. A strobe is either
// driven 0 or released to Z, and data is driven only while writing.
//
// Ports:
//   clk        clock, all state changes on posedge
//   rst        synchronous active-high reset
//   ena_       start request (active-low), sampled only in IDLE
//   op         operation select, latched at start
//   r0_dout    operand A
//   r1_dout    operand B
//   flag_c_in  current carry flag, latched at start
//   rdy_       done strobe, 0 for one cycle else Z
//   r0_din     result bus, driven in WRITE else Z
//   r0_we_     r0 write strobe, 0 in WRITE for non-CMP ops else Z
//   flag_din   {C,Z} bus, driven in WRITE else Z
//   flag_we_   flag write strobe, 0 in WRITE else Z
module step_ex_alu #(
   parameter int WIDTH = 8,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena_,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] r0_dout,
   input  logic [WIDTH-1:0] r1_dout,
   input  logic             flag_c_in,
   output logic             rdy_,
   output logic [WIDTH-1:0] r0_din,
   output logic             r0_we_,
   output logic [1:0]       flag_din,
   output logic             flag_we_
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_ADC = 3'd2;
   localparam logic [2:0] OP_SBC = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_OR  = 3'd5;
   localparam logic [2:0] OP_XOR = 3'd6;
   localparam logic [2:0] OP_CMP = 3'd7;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WRITE = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, res_q;
   logic [2:0]       op_q;
   logic             cin_q;
   logic             carry_q;
   logic [CW-1:0]    k_q;

   logic             start_carry;
   logic             is_sub, is_logic;
   logic [SLICE-1:0] sa, sb, sb_eff, slice_res;
   logic [SLICE:0]   slice_sum;
   logic             drive_en, r0_we_en;
   logic             c_out, z_out;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; ena_ matters only in IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!ena_) state_d = RUN;
         RUN:     if (k_q == CW'(N - 1)) state_d = WRITE;
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Initial carry into slice 0, chosen from the op being started
   always_comb begin
      start_carry = 1'b0;
      case (op)
         OP_SUB, OP_CMP: start_carry = 1'b1;
         OP_ADC, OP_SBC: start_carry = flag_c_in;
         default:        start_carry = 1'b0;
      endcase
   end

   assign is_sub   = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CMP);
   assign is_logic = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_XOR);

   // Select slice k of the latched operands and combine it
   always_comb begin
      sa = '0;
      sb = '0;
      for (int i = 0; i < N; i++) begin
         if (k_q == CW'(i)) begin
            sa = a_q[i*SLICE +: SLICE];
            sb = b_q[i*SLICE +: SLICE];
         end
      end
      sb_eff    = is_sub ? ~sb : sb;
      slice_sum = {1'b0, sa} + {1'b0, sb_eff} + {{SLICE{1'b0}}, carry_q};
      case (op_q)
         OP_AND:  slice_res = sa & sb;
         OP_OR:   slice_res = sa | sb;
         OP_XOR:  slice_res = sa ^ sb;
         default: slice_res = slice_sum[SLICE-1:0];
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         op_q    <= OP_ADD;
         cin_q   <= 1'b0;
         carry_q <= 1'b0;
         k_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!ena_) begin
                  a_q     <= r0_dout;
                  b_q     <= r1_dout;
                  op_q    <= op;
                  cin_q   <= flag_c_in;
                  carry_q <= start_carry;
                  k_q     <= '0;
               end
            end
            RUN: begin
               // Logic ops leave the carry chain untouched
               if (!is_logic) carry_q <= slice_sum[SLICE];
               for (int i = 0; i < N; i++) begin
                  if (k_q == CW'(i)) res_q[i*SLICE +: SLICE] <= slice_res;
               end
               k_q <= k_q + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // Output enables decode only registered state, so no input reaches a pin
   always_comb begin
      drive_en = (state_q == WRITE);
      r0_we_en = (state_q == WRITE) && (op_q != OP_CMP);
      c_out    = is_logic ? cin_q : carry_q;
      z_out    = (res_q == '0);
   end

   assign rdy_     = drive_en ? 1'b0 : 1'bz;
   assign flag_we_ = drive_en ? 1'b0 : 1'bz;
   assign r0_we_   = r0_we_en ? 1'b0 : 1'bz;
   assign r0_din   = drive_en ? res_q : {WIDTH{1'bz}};
   assign flag_din = drive_en ? {c_out, z_out} : 2'bzz;

endmodule

// File: tb/tb_step_ex_alu.sv
// Self-checking bench for step_ex_alu. It uses three instances: 8/4, 16/1 and 16/16.
// Drivers push the expected write-back into a per-instance queue. Monitors
// watch the open-drain strobes, which have pull-ups as on the real bus, and
// pop and compare whenever rdy_ goes low.
module tb_step_ex_alu;

   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, ADC = 3'd2, SBC = 3'd3;
   localparam logic [2:0] AND = 3'd4, OR = 3'd5, XOR = 3'd6, CMP = 3'd7;

   typedef struct packed {
      logic        we;
      logic        c;
      logic        z;
      logic [15:0] res;
      logic [31:0] due;
   } exp_t;
   localparam int EW = $bits(exp_t);

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic [2:0]  ena_v;
   logic [2:0]  op_v  [3];
   logic [15:0] a_v   [3];
   logic [15:0] b_v   [3];
   logic [2:0]  cin_v;

   wire        rdy_a, rdy_b, rdy_c, r0we_a, r0we_b, r0we_c, fwe_a, fwe_b, fwe_c;
   wire [7:0]  r0_din_a;
   wire [15:0] r0_din_b, r0_din_c;
   wire [1:0]  flag_din_a, flag_din_b, flag_din_c;

   pullup (rdy_a);
   pullup (rdy_b);
   pullup (rdy_c);
   pullup (r0we_a);
   pullup (r0we_b);
   pullup (r0we_c);
   pullup (fwe_a);
   pullup (fwe_b);
   pullup (fwe_c);

   step_ex_alu #(.WIDTH(8), .SLICE(4)) u_a (
      .clk(clk), .rst(rst), .ena_(ena_v[0]), .op(op_v[0]),
      .r0_dout(a_v[0][7:0]), .r1_dout(b_v[0][7:0]), .flag_c_in(cin_v[0]),
      .rdy_(rdy_a), .r0_din(r0_din_a), .r0_we_(r0we_a),
      .flag_din(flag_din_a), .flag_we_(fwe_a));

   step_ex_alu #(.WIDTH(16), .SLICE(1)) u_b (
      .clk(clk), .rst(rst), .ena_(ena_v[1]), .op(op_v[1]),
      .r0_dout(a_v[1]), .r1_dout(b_v[1]), .flag_c_in(cin_v[1]),
      .rdy_(rdy_b), .r0_din(r0_din_b), .r0_we_(r0we_b),
      .flag_din(flag_din_b), .flag_we_(fwe_b));

   step_ex_alu #(.WIDTH(16), .SLICE(16)) u_c (
      .clk(clk), .rst(rst), .ena_(ena_v[2]), .op(op_v[2]),
      .r0_dout(a_v[2]), .r1_dout(b_v[2]), .flag_c_in(cin_v[2]),
      .rdy_(rdy_c), .r0_din(r0_din_c), .r0_we_(r0we_c),
      .flag_din(flag_din_c), .flag_we_(fwe_c));

   // scoreboard
   logic [EW-1:0] exp_q0[$];
   logic [EW-1:0] exp_q1[$];
   logic [EW-1:0] exp_q2[$];

   function automatic int qsize(input int idx);
      case (idx)
         0:       return exp_q0.size();
         1:       return exp_q1.size();
         default: return exp_q2.size();
      endcase
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h, required %0h (cycle %0d)", name, idx, act, req, cyc);
      end
   endtask

   task automatic mon(input int idx, input logic rdy, input logic r0we, input logic fwe,
                      input logic [15:0] res, input logic [1:0] fl);
      exp_t e;
      logic have;
      have = 1'b0;
      e    = '0;
      if (rdy !== 1'b0) begin
         chk("idle_r0_we_", idx, {31'd0, r0we}, 32'd1);
         chk("idle_flag_we_", idx, {31'd0, fwe}, 32'd1);
      end else begin
         case (idx)
            0: if (exp_q0.size() > 0) begin e = exp_t'(exp_q0.pop_front()); have = 1'b1; end
            1: if (exp_q1.size() > 0) begin e = exp_t'(exp_q1.pop_front()); have = 1'b1; end
            default: if (exp_q2.size() > 0) begin e = exp_t'(exp_q2.pop_front()); have = 1'b1; end
         endcase
         if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rdy dut%0d: rdy_ low at cycle %0d, required released", idx, cyc);
         end else begin
            chk("rdy_cycle", idx, cyc, e.due);
            chk("result", idx, {16'd0, res}, {16'd0, e.res});
            chk("flag_c", idx, {31'd0, fl[1]}, {31'd0, e.c});
            chk("flag_z", idx, {31'd0, fl[0]}, {31'd0, e.z});
            chk("r0_we_", idx, {31'd0, r0we}, {31'd0, ~e.we});
            chk("flag_we_", idx, {31'd0, fwe}, 32'd0);
         end
      end
   endtask

   always @(negedge clk) mon(0, rdy_a, r0we_a, fwe_a, {8'h00, r0_din_a}, flag_din_a);
   always @(negedge clk) mon(1, rdy_b, r0we_b, fwe_b, r0_din_b, flag_din_b);
   always @(negedge clk) mon(2, rdy_c, r0we_c, fwe_c, r0_din_c, flag_din_c);

   // driver
   task automatic run_op(input int idx, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic cin, input logic [15:0] res,
                         input logic c, input logic z, input logic run_pulse);
      exp_t e;
      int   n;
      n = (idx == 0) ? 2 : (idx == 1) ? 16 : 1;
      @(negedge clk);
      op_v[idx]  = op;
      a_v[idx]   = a;
      b_v[idx]   = b;
      cin_v[idx] = cin;
      ena_v[idx] = 1'b0;
      @(negedge clk);
      ena_v[idx] = 1'b1;
      // operands are latched; scrambling them must not matter
      a_v[idx]   = 16'($urandom);
      b_v[idx]   = 16'($urandom);
      op_v[idx]  = 3'($urandom_range(0, 7));
      cin_v[idx] = ~cin;
      e.we  = (op != CMP);
      e.c   = c;
      e.z   = z;
      e.res = res;
      e.due = 32'(cyc + n);
      case (idx)
         0:       exp_q0.push_back(EW'(e));
         1:       exp_q1.push_back(EW'(e));
         default: exp_q2.push_back(EW'(e));
      endcase
      if (run_pulse) begin
         ena_v[idx] = 1'b0;
         @(negedge clk);
         ena_v[idx] = 1'b1;
      end
      for (int t = 0; t < 40; t++) begin
         if (qsize(idx) == 0) break;
         @(negedge clk);
      end
      checks++;
      if (qsize(idx) != 0) begin
         errors++;
         $display("FAIL timeout dut%0d: no rdy_ within 40 cycles, required rdy_ at cycle %0d", idx, e.due);
         case (idx)
            0:       exp_q0.delete();
            1:       exp_q1.delete();
            default: exp_q2.delete();
         endcase
      end
   endtask

   task automatic reset_mid_op();
      @(negedge clk);
      op_v[0]  = ADD;
      a_v[0]   = 16'h003C;
      b_v[0]   = 16'h0055;
      cin_v[0] = 1'b0;
      ena_v[0] = 1'b0;
      @(negedge clk);
      ena_v[0] = 1'b1;
      rst      = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      // any strobe from the aborted op is caught as unexpected_rdy
      repeat (6) @(negedge clk);
   endtask

   initial begin
      rst   = 1'b1;
      ena_v = 3'b111;
      cin_v = 3'b000;
      for (int i = 0; i < 3; i++) begin
         op_v[i] = ADD;
         a_v[i]  = '0;
         b_v[i]  = '0;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_op(0, ADD, 16'h003C, 16'h0055, 1'b0, 16'h0091, 1'b0, 1'b0, 1'b0);
      run_op(0, ADC, 16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
      run_op(0, SBC, 16'h0000, 16'h00FF, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
      run_op(0, SUB, 16'h0010, 16'h0020, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0);
      run_op(0, CMP, 16'h0042, 16'h0042, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      run_op(0, AND, 16'h00F0, 16'h000F, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
      run_op(0, XOR, 16'h00AA, 16'h00FF, 1'b1, 16'h0055, 1'b1, 1'b0, 1'b0);
      run_op(0, OR,  16'h0012, 16'h0040, 1'b0, 16'h0052, 1'b0, 1'b0, 1'b0);
      run_op(0, ADD, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      reset_mid_op();
      run_op(0, ADD, 16'h003C, 16'h0055, 1'b0, 16'h0091, 1'b0, 1'b0, 1'b0);
      run_op(0, ADD, 16'h0001, 16'h0002, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b1);
      run_op(1, ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      run_op(2, ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      run_op(1, SUB, 16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b1, 1'b0, 1'b0);
      run_op(2, SBC, 16'h1234, 16'h0235, 1'b0, 16'h0FFE, 1'b1, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/step_ex_alu.md
# step_ex_alu

Parametrised multi-op execute step for the sequencer's EX stage. It generalises the single-function subtract step into an 8-op ALU of configurable width. Arithmetic is evaluated digit-serially, SLICE bits per clock, with carry chained between slices. The write-back to r0 and to the C/Z flags uses the shared open-drain strobe and tri-state data bus convention of the other step_* blocks.

## Interface
Parameters:
- WIDTH, 8, register/datapath width in bits
- SLICE, 4, bits processed per clock; WIDTH % SLICE must be 0; N = WIDTH/SLICE

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset, synchronous, active-high
- ena_  in  1  start request, active-low, sampled only in IDLE
- op  in  3  operation select, latched at start
- r0_dout  in  WIDTH  operand A (r0)
- r1_dout  in  WIDTH  operand B (r1)
- flag_c_in  in  1  current carry flag, latched at start
- rdy_  out  1  done strobe; driven 0 for one cycle, else Z
- r0_din  out  WIDTH  result; driven in WRITE, else Z
- r0_we_  out  1  r0 write strobe; driven 0 in WRITE for non-CMP ops, else Z
- flag_din  out  2  {C,Z}; driven in WRITE, else Z
- flag_we_  out  1  flag write strobe; driven 0 in WRITE, else Z

## Operation
- Ops:
  - 0 ADD: A+B, cin=0
  - 1 SUB: A+~B, cin=1
  - 2 ADC: A+B, cin=flag_c_in
  - 3 SBC: A+~B, cin=flag_c_in
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 CMP: as SUB, no r0 write
- C semantics: arithmetic C = carry out of the MSB slice; for subtract ops C=1 means no borrow. Logic ops output C=flag_c_in unchanged.
- Z = (WIDTH-bit result == 0) for all ops, including CMP.
- The result is computed modulo 2^WIDTH; overflow is discarded apart from C.
- States: IDLE, RUN, WRITE.
  - IDLE: on ena_=0 latch A, B, op, cin; clear slice counter; go to RUN.
  - RUN: each cycle, combine slice k (bits k·SLICE..k·SLICE+SLICE-1) of A and B using the carry register; store the slice into the result register; update carry; k++. After slice N-1, go to WRITE.
  - WRITE: drive r0_din, flag_din, flag_we_=0, rdy_=0, and r0_we_=0 (CMP: r0_we_ stays Z). Go to IDLE next cycle.
- r0_dout, r1_dout and op changes after the start edge have no effect.
- ena_ is ignored in RUN and WRITE. ena_ held low in IDLE starts a new operation on each IDLE edge, which gives back-to-back ops with one IDLE cycle between them.
- rst=1 at any posedge forces IDLE and releases all outputs to Z. An in-flight op is aborted with no write and no rdy_. rst has priority over ena_.
- All driven-0/Z outputs come from registered enables, with no combinational path from inputs to outputs.

## Timing
- Reset value: rdy_, r0_we_, flag_we_ = Z; r0_din, flag_din = Z; state = IDLE.
- Start edge E0 samples ena_=0. Slices are processed at edges E1..EN. Outputs are valid and strobes low from EN until EN+1, exactly one cycle, then Z.
- Latency from the start edge to the rdy_ assertion edge is N cycles. Occupancy is N+1 cycles including WRITE.
- The next start can be sampled at E(N+2) at the earliest.
- SLICE=WIDTH (N=1): RUN lasts one cycle and the behaviour matches a single-cycle step.

## Test plan
- ADD, WIDTH=8, SLICE=4: A=8'h3C, B=8'h55 -> r0_din=8'h91, C=0, Z=0. rdy_/r0_we_/flag_we_ low exactly in the cycle after E2, Z before and after.
- Inter-slice carry, ADC: A=8'h0F, B=8'h00, flag_c_in=1 -> 8'h10, C=0. Also SBC with A=8'h00, B=8'hFF, flag_c_in=1 -> 8'h01, C=0 (borrow).
- SUB 8'h10-8'h20 -> 8'hF0, C=0, Z=0. CMP 8'h42 vs 8'h42 -> r0_we_ stays Z for the whole op, flag_din={1,1}, flag_we_ low for one cycle.
- Logic ops with flag_c_in=1: AND 8'hF0&8'h0F -> 8'h00, Z=1, C=1. XOR 8'hAA^8'hFF -> 8'h55, Z=0, C=1.
- Reset mid-op: start ADD, assert rst at E1 -> no strobe ever goes low, all outputs Z. An ena_ pulse after rst deasserts yields a correct result. ena_ pulses during RUN are ignored.
- Parametric: WIDTH=16, SLICE=1, ADD 16'hFFFF+16'h0001 -> 16'h0000, C=1, Z=1, rdy_ at E16. WIDTH=16, SLICE=16 -> same result at E1.
